// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the in-order MEM/WB result with a buffered long-latency
// result onto the single register file write port. Load formatting is applied here.
module wb_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic            i_wb_is_load,
  input  logic [2:0]      i_wb_funct3,
  input  logic [1:0]      i_wb_addr_lo,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_lu_valid,
  output logic            o_lu_ready,
  input  logic [4:0]      i_lu_rd,
  input  logic [XLEN-1:0] i_lu_data,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_stall,
  output logic            o_pending,
  output logic [4:0]      o_pending_rd
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic            buf_valid_q, buf_valid_d;
  logic [4:0]      buf_rd_q, buf_rd_d;
  logic [XLEN-1:0] buf_data_q, buf_data_d;
  logic [3:0]      starve_q, starve_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [XLEN-1:0] wb_fmt;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic            pipe_we;
  logic            lu_hs;

  assign o_lu_ready   = i_reset_n & ~buf_valid_q;
  // Gated by reset so a buffer that is about to be discarded never freezes the pipe.
  assign o_stall      = i_reset_n & buf_valid_q & (starve_q == StarveMax);
  assign o_pending    = buf_valid_q;
  assign o_pending_rd = buf_valid_q ? buf_rd_q : 5'd0;
  assign o_rd         = rd_q;
  assign o_rd_data    = rd_data_q;
  assign pipe_we      = i_wb_valid & (i_wb_rd != 5'd0);
  assign lu_hs        = i_lu_valid & o_lu_ready;

  // Load result formatting (byte/half select with sign or zero extension).
  always_comb begin
    ld_byte = i_wb_data[8*i_wb_addr_lo +: 8];
    ld_half = i_wb_data[16*i_wb_addr_lo[1] +: 16];
    wb_fmt  = i_wb_data;
    if (i_wb_is_load) begin
      case (i_wb_funct3)
        3'b000:  wb_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
        3'b100:  wb_fmt = {{(XLEN-8){1'b0}}, ld_byte};
        3'b001:  wb_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
        3'b101:  wb_fmt = {{(XLEN-16){1'b0}}, ld_half};
        default: wb_fmt = i_wb_data;
      endcase
    end
  end

  // Arbitration between forced drain, pipe write, idle-slot drain, and buffer capture.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    starve_d    = starve_q;
    rd_d        = 5'd0;
    rd_data_d   = rd_data_q;
    if (o_stall) begin
      rd_d        = buf_rd_q;
      rd_data_d   = buf_data_q;
      buf_valid_d = 1'b0;
      starve_d    = 4'd0;
    end else if (pipe_we) begin
      rd_d      = i_wb_rd;
      rd_data_d = wb_fmt;
      if (buf_valid_q) starve_d = starve_q + 4'd1;
    end else if (buf_valid_q) begin
      rd_d        = buf_rd_q;
      rd_data_d   = buf_data_q;
      buf_valid_d = 1'b0;
      starve_d    = 4'd0;
    end
    // Capture only happens with the buffer empty; rd=0 results are accepted and dropped.
    if (lu_hs && (i_lu_rd != 5'd0)) begin
      buf_valid_d = 1'b1;
      buf_rd_d    = i_lu_rd;
      buf_data_d  = i_lu_data;
      starve_d    = 4'd0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= 5'd0;
      buf_data_q  <= '0;
      starve_q    <= 4'd0;
      rd_q        <= 5'd0;
      rd_data_q   <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      starve_q    <= starve_d;
      rd_q        <= rd_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule
